// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin mux arbiter.
//   NUM_REQ / IDX_W : requester count and index width
//   arb_state_e     : controller states
//   idx_to_onehot   : index -> MSB-first one-hot (00 -> 1000, 11 -> 0001)
package arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN  = 2'b01,
        GAP  = 2'b10
    } arb_state_e;

    // Requester 0 sits on the MSB, so bit position is (NUM_REQ-1 - idx).
    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] oh;
        oh = '0;
        oh[IDX_W'(NUM_REQ-1) - idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotating-priority picker.
//   req     : MSB-first request lines (req[3] = requester 0)
//   pointer : requester holding highest priority this round
//   winner  : first requesting index searching pointer, pointer+1, ... mod 4
//   any_req : at least one request present
module rr_priority_pick
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   pointer,
    output logic [IDX_W-1:0]   winner,
    output logic               any_req
);

    logic [IDX_W-1:0] idx;

    // Scan from lowest priority to highest so the nearest requester to the
    // pointer is written last and wins.
    always_comb begin
        winner  = '0;
        idx     = '0;
        any_req = |req;
        for (int k = NUM_REQ-1; k >= 0; k--) begin
            idx = pointer + IDX_W'(k);
            if (req[IDX_W'(NUM_REQ-1) - idx])
                winner = idx;
        end
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one 4:1 mux between four requesters.
//   clk, reset  : clock, synchronous active-high reset
//   req         : MSB-first request lines (req[3] = requester 0)
//   done        : owner release, only honoured while granted
//   grant       : one-hot MSB-first grant, 0000 when none
//   grant_idx   : current/last owner index, drives mux select
//   grant_valid : a grant is active
//   timeout     : one-cycle pulse when ownership ended purely by MAX_HOLD
module rr_mux_arbiter
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid,
    output logic               timeout
);

    arb_state_e         state, state_n;
    logic [IDX_W-1:0]   pointer, pointer_n;
    logic [CNT_W-1:0]   hold_cnt, hold_cnt_n;
    logic [NUM_REQ-1:0] grant_n;
    logic [IDX_W-1:0]   grant_idx_n;
    logic               grant_valid_n;
    logic               timeout_n;

    logic [IDX_W-1:0]   winner;
    logic               any_req;
    logic               owner_req;
    logic               hold_max;

    rr_priority_pick u_pick (
        .req     (req),
        .pointer (pointer),
        .winner  (winner),
        .any_req (any_req)
    );

    assign owner_req = req[IDX_W'(NUM_REQ-1) - grant_idx];
    assign hold_max  = (hold_cnt == CNT_W'(MAX_HOLD-1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pointer     <= '0;
            hold_cnt    <= '0;
            grant       <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            state       <= state_n;
            pointer     <= pointer_n;
            hold_cnt    <= hold_cnt_n;
            grant       <= grant_n;
            grant_idx   <= grant_idx_n;
            grant_valid <= grant_valid_n;
            timeout     <= timeout_n;
        end
    end

    always_comb begin
        state_n       = state;
        pointer_n     = pointer;
        hold_cnt_n    = hold_cnt;
        grant_n       = grant;
        grant_idx_n   = grant_idx;
        grant_valid_n = grant_valid;
        timeout_n     = 1'b0;
        case (state)
            IDLE, GAP: begin
                // GAP arbitrates like IDLE; its one-cycle duration is what
                // keeps the mux select from moving under a live owner.
                if (any_req) begin
                    grant_n       = idx_to_onehot(winner);
                    grant_idx_n   = winner;
                    grant_valid_n = 1'b1;
                    hold_cnt_n    = '0;
                    state_n       = OWN;
                end else begin
                    state_n = IDLE;
                end
            end
            OWN: begin
                hold_cnt_n = hold_cnt + 1'b1;
                if (done || !owner_req || hold_max) begin
                    grant_n       = '0;
                    grant_valid_n = 1'b0;
                    pointer_n     = grant_idx + 1'b1;
                    state_n       = GAP;
                    // grant_idx is left alone so the select stays parked.
                    timeout_n     = hold_max && owner_req && !done;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
